wordcount_job_sched: RTL

WORDCOUNT_JOB_SCHED -- requirements
Module: wordcount_job_sched

---
 rtl/wordcount_job_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/wordcount_job_sched.sv
// -----------------------------------------------------------------------------
// wordcount_job_sched
//
// Splits one word-count job into lane-sized chunks. Each chunk is handed to
// the lane engine with a single-cycle kick. The scheduler waits for the lane
// to raise busy and then drop it before it issues the next chunk.
//
// Handshake: a job is accepted on a rising clk edge where job_valid and
// job_ready are both high. job_ready is high only while idle. The requester
// holds job_valid, job_num_words and job_addr steady until that edge.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   job_valid/job_ready   job request handshake
//   job_num_words         total 128-bit words in the job
//   job_addr              byte offset of the first word
//   abort                 stop issuing chunks (sticky until FINISH)
//   job_done              one-cycle completion pulse
//   job_status            0 ok, 1 aborted, 2 timeout (valid with job_done)
//   chunks_done           chunks completed in the current/last job
//   sched_busy            high whenever the FSM is not idle
//   sac_ready/sac_busy    lane engine status
//   sac_kick              one-cycle lane start pulse
//   sac_num_of_words      words in the current chunk
//   sac_memory_offset     byte offset of the current chunk
//   state_dbg             current FSM state, for observation only
// -----------------------------------------------------------------------------
module wordcount_job_sched #(
  parameter int unsigned CHUNK_WORDS  = 256,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_num_words,
  input  logic [63:0] job_addr,
  input  logic        abort,
  output logic        job_done,
  output logic [1:0]  job_status,
  output logic [31:0] chunks_done,
  output logic        sched_busy,
  input  logic        sac_ready,
  output logic        sac_kick,
  input  logic        sac_busy,
  output logic [31:0] sac_num_of_words,
  output logic [63:0] sac_memory_offset,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_READY = 3'd1;
  localparam logic [2:0] S_KICK       = 3'd2;
  localparam logic [2:0] S_WAIT_HI    = 3'd3;
  localparam logic [2:0] S_WAIT_LO    = 3'd4;
  localparam logic [2:0] S_NEXT       = 3'd5;
  localparam logic [2:0] S_FINISH     = 3'd6;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ABORT   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [31:0] CHUNK_W = 32'(CHUNK_WORDS);

  // The counter holds 0..BUSY_TIMEOUT-1, one count per WAIT_HI cycle.
  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [31:0]   rem_q, rem_d;
  logic [63:0]   addr_q, addr_d;
  logic [31:0]   num_q, num_d;
  logic [63:0]   off_q, off_d;
  logic [31:0]   chunks_q, chunks_d;
  logic          abort_q, abort_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]    status_q, status_d;
  logic          ready_q, ready_d;

  logic [31:0]   chunk_sz;
  logic [31:0]   rem_after;
  logic [63:0]   addr_step;
  logic          abort_seen;

  // Chunk never exceeds what is left, so rem cannot underflow.
  assign chunk_sz   = (rem_q > CHUNK_W) ? CHUNK_W : rem_q;
  assign rem_after  = rem_q - num_q;
  assign addr_step  = {28'd0, num_q, 4'd0};
  // The flag plus the live input, so an abort raised in the deciding
  // cycle itself is not lost.
  assign abort_seen = abort_q | abort;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    num_d    = num_q;
    off_d    = off_q;
    chunks_d = chunks_q;
    to_cnt_d = to_cnt_q;
    status_d = status_q;

    case (state_q)
      S_IDLE: begin
        if (job_valid && ready_q) begin
          rem_d    = job_num_words;
          addr_d   = job_addr;
          chunks_d = 32'd0;
          state_d  = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        // An empty job completes without ever touching the lane.
        if (rem_q == 32'd0) begin
          state_d  = S_FINISH;
          status_d = ST_OK;
        end else if (abort_seen) begin
          state_d  = S_FINISH;
          status_d = ST_ABORT;
        end else if (sac_ready && !sac_busy) begin
          state_d = S_KICK;
          num_d   = chunk_sz;
          off_d   = addr_q;
        end
      end
      S_KICK: begin
        state_d  = S_WAIT_HI;
        to_cnt_d = '0;
      end
      S_WAIT_HI: begin
        if (sac_busy) begin
          state_d = S_WAIT_LO;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = S_FINISH;
          status_d = ST_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!sac_busy) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        chunks_d = chunks_q + 32'd1;
        rem_d    = rem_after;
        addr_d   = addr_q + addr_step;
        if (abort_seen) begin
          state_d  = S_FINISH;
          status_d = ST_ABORT;
        end else if (rem_after == 32'd0) begin
          state_d  = S_FINISH;
          status_d = ST_OK;
        end else begin
          state_d = S_WAIT_READY;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky abort: ignored while idle, dropped once the job finishes.
    abort_d = abort_q;
    if (state_q == S_FINISH) begin
      abort_d = 1'b0;
    end else if (state_q != S_IDLE && abort) begin
      abort_d = 1'b1;
    end

    // Registered so it stays low through reset and rises on the first edge.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rem_q    <= 32'd0;
      addr_q   <= 64'd0;
      num_q    <= 32'd0;
      off_q    <= 64'd0;
      chunks_q <= 32'd0;
      abort_q  <= 1'b0;
      to_cnt_q <= '0;
      status_q <= ST_OK;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      num_q    <= num_d;
      off_q    <= off_d;
      chunks_q <= chunks_d;
      abort_q  <= abort_d;
      to_cnt_q <= to_cnt_d;
      status_q <= status_d;
      ready_q  <= ready_d;
    end
  end

  assign job_ready         = ready_q;
  assign job_done          = (state_q == S_FINISH);
  assign job_status        = status_q;
  assign chunks_done       = chunks_q;
  assign sched_busy        = (state_q != S_IDLE);
  assign sac_kick          = (state_q == S_KICK);
  assign sac_num_of_words  = num_q;
  assign sac_memory_offset = off_q;
  assign state_dbg         = state_q;

endmodule
